// File: rtl/rvh_pmp_pkg.sv
// Shared PMP encodings: access types, privilege levels, pmpcfg.A modes
// and the state encoding of the PMP check sequencer.
package rvh_pmp_pkg;

    localparam logic [1:0] PMP_ACCESS_TYPE_R = 2'd0;
    localparam logic [1:0] PMP_ACCESS_TYPE_W = 2'd1;
    localparam logic [1:0] PMP_ACCESS_TYPE_X = 2'd2;

    localparam logic [1:0] PRIV_LVL_U = 2'd0;
    localparam logic [1:0] PRIV_LVL_S = 2'd1;
    localparam logic [1:0] PRIV_LVL_M = 2'd3;

    localparam logic [1:0] PMPCFG_A_OFF   = 2'd0;
    localparam logic [1:0] PMPCFG_A_TOR   = 2'd1;
    localparam logic [1:0] PMPCFG_A_NA4   = 2'd2;
    localparam logic [1:0] PMPCFG_A_NAPOT = 2'd3;

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_CHECK = 2'd1,
        CHK_RESP  = 2'd2
    } pmp_chk_state_e;

endpackage

// File: rtl/rvh_pmp_check_ctrl_if.sv
// Bundle of requester, entry-array and response signals around the PMP
// check sequencer. slave = the sequencer, master = its surroundings.
interface rvh_pmp_check_ctrl_if #(
    parameter int NUM_REQ     = 3,
    parameter int NUM_ENTRY   = 16,
    parameter int PADDR_WIDTH = 56
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

    logic [NUM_REQ-1:0]             req_vld_i;
    logic [NUM_REQ*PADDR_WIDTH-1:0] req_paddr_i;
    logic [NUM_REQ*2-1:0]           req_access_type_i;
    logic [NUM_REQ*2-1:0]           req_priv_lvl_i;
    logic [NUM_REQ-1:0]             req_rdy_o;

    logic                           chk_vld_o;
    logic [PADDR_WIDTH-1:0]         chk_paddr_o;
    logic [1:0]                     chk_access_type_o;
    logic [NUM_ENTRY-1:0]           entry_match_i;
    logic [NUM_ENTRY-1:0]           entry_fail_i;
    logic [NUM_ENTRY-1:0]           entry_lock_i;
    logic [NUM_ENTRY-1:0]           entry_active_i;

    logic                           cfg_wr_pend_i;
    logic                           flush_i;

    logic                           resp_vld_o;
    logic [ID_W-1:0]                resp_id_o;
    logic                           resp_fail_o;
    logic                           resp_hit_o;
    logic [IDX_W-1:0]               resp_hit_idx_o;
    logic                           resp_rdy_i;

    modport slave (
        input  req_vld_i, req_paddr_i, req_access_type_i, req_priv_lvl_i,
        output req_rdy_o,
        output chk_vld_o, chk_paddr_o, chk_access_type_o,
        input  entry_match_i, entry_fail_i, entry_lock_i, entry_active_i,
        input  cfg_wr_pend_i, flush_i,
        output resp_vld_o, resp_id_o, resp_fail_o, resp_hit_o, resp_hit_idx_o,
        input  resp_rdy_i
    );

    modport master (
        output req_vld_i, req_paddr_i, req_access_type_i, req_priv_lvl_i,
        input  req_rdy_o,
        input  chk_vld_o, chk_paddr_o, chk_access_type_o,
        output entry_match_i, entry_fail_i, entry_lock_i, entry_active_i,
        output cfg_wr_pend_i, flush_i,
        input  resp_vld_o, resp_id_o, resp_fail_o, resp_hit_o, resp_hit_idx_o,
        output resp_rdy_i
    );

endinterface

// File: rtl/rvh_pmp_prio_enc.sv
// Lowest-index-first priority encoder; idx_o is 0 when nothing is set.
module rvh_pmp_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    assign vld_o = |req_i;

    // Scan downward so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rvh_pmp_check_ctrl.sv
// Round-robin shared PMP check port: grants one requester, strobes the
// entry array for one cycle and holds a registered verdict until accepted.
module rvh_pmp_check_ctrl
    import rvh_pmp_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int NUM_ENTRY   = 16,
    parameter int PADDR_WIDTH = 56
) (
    input  logic clk,
    input  logic rstn,
    rvh_pmp_check_ctrl_if.slave bus
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
    localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(NUM_REQ);

    pmp_chk_state_e         state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [ID_W-1:0]        id_q;
    logic [PADDR_WIDTH-1:0] paddr_q;
    logic [1:0]             acc_q;
    logic [1:0]             priv_q;
    logic                   resp_fail_q;
    logic                   resp_hit_q;
    logic [IDX_W-1:0]       resp_hit_idx_q;

    logic [PADDR_WIDTH-1:0] paddr_arr [NUM_REQ];
    logic [1:0]             acc_arr   [NUM_REQ];
    logic [1:0]             priv_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]     rot_vld;

    // Rotate the valid vector so that bit 0 is the requester at rr_ptr.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [ID_W:0]   rot_sum;
        logic [ID_W-1:0] rot_sel;
        assign paddr_arr[gi] = bus.req_paddr_i[gi*PADDR_WIDTH +: PADDR_WIDTH];
        assign acc_arr[gi]   = bus.req_access_type_i[gi*2 +: 2];
        assign priv_arr[gi]  = bus.req_priv_lvl_i[gi*2 +: 2];
        assign rot_sum       = {1'b0, rr_ptr_q} + (ID_W + 1)'(gi);
        assign rot_sel       = ID_W'((rot_sum >= NREQ_W) ? rot_sum - NREQ_W : rot_sum);
        assign rot_vld[gi]   = bus.req_vld_i[rot_sel];
    end

    logic            any_vld;
    logic [ID_W-1:0] rot_idx;
    logic [ID_W:0]   grant_sum;
    logic [ID_W-1:0] grant_id;
    logic [ID_W:0]   next_sum;
    logic [ID_W-1:0] rr_ptr_d;
    logic            grant_en;
    logic [NUM_REQ-1:0] req_rdy;

    rvh_pmp_prio_enc #(.WIDTH(NUM_REQ), .IDX_W(ID_W)) u_rr_enc (
        .req_i (rot_vld),
        .vld_o (any_vld),
        .idx_o (rot_idx)
    );

    assign grant_sum = {1'b0, rr_ptr_q} + {1'b0, rot_idx};
    assign grant_id  = ID_W'((grant_sum >= NREQ_W) ? grant_sum - NREQ_W : grant_sum);
    assign next_sum  = {1'b0, grant_id} + (ID_W + 1)'(1);
    assign rr_ptr_d  = ID_W'((next_sum >= NREQ_W) ? next_sum - NREQ_W : next_sum);

    // New grants only from IDLE or on the response handshake; flush and a
    // pending CSR write both suppress them.
    assign grant_en = rstn && !bus.flush_i && !bus.cfg_wr_pend_i && any_vld &&
                      ((state_q == CHK_IDLE) ||
                       ((state_q == CHK_RESP) && bus.resp_rdy_i));

    always_comb begin
        req_rdy = '0;
        if (grant_en) begin
            req_rdy[grant_id] = 1'b1;
        end
    end

    logic             entry_hit;
    logic [IDX_W-1:0] entry_idx;
    logic             verdict_fail;

    rvh_pmp_prio_enc #(.WIDTH(NUM_ENTRY), .IDX_W(IDX_W)) u_entry_enc (
        .req_i (bus.entry_match_i),
        .vld_o (entry_hit),
        .idx_o (entry_idx)
    );

    // M-mode bypasses unlocked entries and the no-match default-deny.
    always_comb begin
        verdict_fail = 1'b0;
        if (entry_hit) begin
            if ((priv_q == PRIV_LVL_M) && !bus.entry_lock_i[entry_idx]) begin
                verdict_fail = 1'b0;
            end else begin
                verdict_fail = bus.entry_fail_i[entry_idx];
            end
        end else begin
            verdict_fail = (priv_q != PRIV_LVL_M) && (|bus.entry_active_i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CHK_IDLE: begin
                if (grant_en) begin
                    state_d = CHK_CHECK;
                end
            end
            CHK_CHECK: begin
                state_d = bus.flush_i ? CHK_IDLE : CHK_RESP;
            end
            CHK_RESP: begin
                if (bus.flush_i) begin
                    state_d = CHK_IDLE;
                end else if (bus.resp_rdy_i) begin
                    state_d = grant_en ? CHK_CHECK : CHK_IDLE;
                end
            end
            default: state_d = CHK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= CHK_IDLE;
            rr_ptr_q       <= '0;
            id_q           <= '0;
            paddr_q        <= '0;
            acc_q          <= '0;
            priv_q         <= '0;
            resp_fail_q    <= 1'b0;
            resp_hit_q     <= 1'b0;
            resp_hit_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                id_q     <= grant_id;
                paddr_q  <= paddr_arr[grant_id];
                acc_q    <= acc_arr[grant_id];
                priv_q   <= priv_arr[grant_id];
                rr_ptr_q <= rr_ptr_d;
            end
            if ((state_q == CHK_CHECK) && !bus.flush_i) begin
                resp_fail_q    <= verdict_fail;
                resp_hit_q     <= entry_hit;
                resp_hit_idx_q <= entry_idx;
            end
        end
    end

    assign bus.req_rdy_o         = req_rdy;
    assign bus.chk_vld_o         = (state_q == CHK_CHECK);
    assign bus.chk_paddr_o       = paddr_q;
    assign bus.chk_access_type_o = acc_q;
    assign bus.resp_vld_o        = (state_q == CHK_RESP);
    assign bus.resp_id_o         = id_q;
    assign bus.resp_fail_o       = resp_fail_q;
    assign bus.resp_hit_o        = resp_hit_q;
    assign bus.resp_hit_idx_o    = resp_hit_idx_q;

endmodule

// File: tb/tb_rvh_pmp_check_ctrl.sv
// Directed bench for rvh_pmp_check_ctrl: inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_rvh_pmp_check_ctrl;

    localparam int NR = 3;
    localparam int NE = 16;
    localparam int PW = 56;

    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rvh_pmp_check_ctrl_if #(.NUM_REQ(NR), .NUM_ENTRY(NE), .PADDR_WIDTH(PW)) bus ();

    rvh_pmp_check_ctrl #(.NUM_REQ(NR), .NUM_ENTRY(NE), .PADDR_WIDTH(PW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.req_vld_i         = '0;
        bus.req_paddr_i       = '0;
        bus.req_access_type_i = '0;
        bus.req_priv_lvl_i    = '0;
        bus.entry_match_i     = '0;
        bus.entry_fail_i      = '0;
        bus.entry_lock_i      = '0;
        bus.entry_active_i    = '0;
        bus.cfg_wr_pend_i     = 1'b0;
        bus.flush_i           = 1'b0;
        bus.resp_rdy_i        = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [PW-1:0] paddr,
                           input logic [1:0] acc, input logic [1:0] priv);
        bus.req_vld_i[i]                = 1'b1;
        bus.req_paddr_i[i*PW +: PW]     = paddr;
        bus.req_access_type_i[i*2 +: 2] = acc;
        bus.req_priv_lvl_i[i*2 +: 2]    = priv;
    endtask

    task automatic set_ent(input logic [NE-1:0] m, input logic [NE-1:0] f,
                           input logic [NE-1:0] l, input logic [NE-1:0] a);
        bus.entry_match_i  = m;
        bus.entry_fail_i   = f;
        bus.entry_lock_i   = l;
        bus.entry_active_i = a;
    endtask

    // Drives one isolated transaction from IDLE and returns what was seen.
    task automatic run_txn(input int id, input logic [PW-1:0] paddr,
                           input logic [1:0] acc, input logic [1:0] priv,
                           input logic [NE-1:0] m, input logic [NE-1:0] f,
                           input logic [NE-1:0] l, input logic [NE-1:0] a,
                           output logic [NR-1:0] g_rdy, output logic g_chk_vld,
                           output logic [PW-1:0] g_chk_paddr, output logic [1:0] g_chk_acc,
                           output logic g_vld, output logic [1:0] g_id,
                           output logic g_fail, output logic g_hit,
                           output logic [3:0] g_idx, output logic g_vld_after);
        @(negedge clk);
        set_req(id, paddr, acc, priv);
        #1 g_rdy = bus.req_rdy_o;
        @(negedge clk);
        bus.req_vld_i = '0;
        set_ent(m, f, l, a);
        #1;
        g_chk_vld   = bus.chk_vld_o;
        g_chk_paddr = bus.chk_paddr_o;
        g_chk_acc   = bus.chk_access_type_o;
        @(negedge clk);
        #1;
        g_vld  = bus.resp_vld_o;
        g_id   = bus.resp_id_o;
        g_fail = bus.resp_fail_o;
        g_hit  = bus.resp_hit_o;
        g_idx  = bus.resp_hit_idx_o;
        bus.resp_rdy_i = 1'b1;
        @(negedge clk);
        bus.resp_rdy_i = 1'b0;
        set_ent('0, '0, '0, '0);
        #1 g_vld_after = bus.resp_vld_o;
        $display("txn id=%0d paddr=%h acc=%0d priv=%0d -> rdy=%b vld=%0b rid=%0d hit=%0b idx=%0d fail=%0b",
                 id, paddr, acc, priv, g_rdy, g_vld, g_id, g_hit, g_idx, g_fail);
    endtask

    logic [NR-1:0] t_rdy;
    logic          t_chk_vld, t_vld, t_fail, t_hit, t_vld_after;
    logic [PW-1:0] t_chk_paddr;
    logic [1:0]    t_chk_acc, t_id;
    logic [3:0]    t_idx;

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        set_req(0, 56'h1234, 2'd1, 2'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.req_rdy_o !== 3'b000) begin failures++; $display("FAIL reset_rdy got=%b exp=000", bus.req_rdy_o); end
        checks++; if (bus.chk_vld_o !== 1'b0) begin failures++; $display("FAIL reset_chk_vld got=%b exp=0", bus.chk_vld_o); end
        checks++; if (bus.resp_vld_o !== 1'b0) begin failures++; $display("FAIL reset_resp_vld got=%b exp=0", bus.resp_vld_o); end
        checks++; if (bus.chk_paddr_o !== 56'h0) begin failures++; $display("FAIL reset_chk_paddr got=%h exp=0", bus.chk_paddr_o); end
        checks++; if ({bus.resp_fail_o, bus.resp_hit_o, bus.resp_hit_idx_o, bus.resp_id_o} !== 8'h00) begin
            failures++; $display("FAIL reset_resp_fields got=%b exp=0", {bus.resp_fail_o, bus.resp_hit_o, bus.resp_hit_idx_o, bus.resp_id_o});
        end
        $display("txn reset rdy=%b resp_vld=%b", bus.req_rdy_o, bus.resp_vld_o);
        clear_inputs();
        rstn = 1'b1;
    endtask

    task automatic test_single_ptw();
        run_txn(0, 56'h0000_0000_8000_0000, 2'd0, 2'd1, 16'h0024, 16'h0020, 16'h0000, 16'h0024,
                t_rdy, t_chk_vld, t_chk_paddr, t_chk_acc, t_vld, t_id, t_fail, t_hit, t_idx, t_vld_after);
        checks++; if (t_rdy !== 3'b001) begin failures++; $display("FAIL ptw_grant got=%b exp=001", t_rdy); end
        checks++; if (t_chk_vld !== 1'b1) begin failures++; $display("FAIL ptw_chk_vld got=%b exp=1", t_chk_vld); end
        checks++; if (t_chk_paddr !== 56'h8000_0000) begin failures++; $display("FAIL ptw_chk_paddr got=%h exp=80000000", t_chk_paddr); end
        checks++; if (t_chk_acc !== 2'd0) begin failures++; $display("FAIL ptw_chk_acc got=%0d exp=0", t_chk_acc); end
        checks++; if (t_vld !== 1'b1) begin failures++; $display("FAIL ptw_resp_vld got=%b exp=1", t_vld); end
        checks++; if (t_id !== 2'd0) begin failures++; $display("FAIL ptw_resp_id got=%0d exp=0", t_id); end
        checks++; if (t_hit !== 1'b1) begin failures++; $display("FAIL ptw_hit got=%b exp=1", t_hit); end
        checks++; if (t_idx !== 4'd2) begin failures++; $display("FAIL ptw_hit_idx got=%0d exp=2", t_idx); end
        checks++; if (t_fail !== 1'b0) begin failures++; $display("FAIL ptw_fail got=%b exp=0", t_fail); end
        checks++; if (t_vld_after !== 1'b0) begin failures++; $display("FAIL ptw_vld_after got=%b exp=0", t_vld_after); end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] exp_rdy [8];
        int            exp_id  [8];
        exp_rdy = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        exp_id  = '{-1, -1, 0, -1, 1, -1, 2, -1};
        do_reset();
        @(negedge clk);
        set_req(0, 56'h100, 2'd0, 2'd1);
        set_req(1, 56'h200, 2'd2, 2'd1);
        set_req(2, 56'h300, 2'd1, 2'd1);
        bus.resp_rdy_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (bus.req_rdy_o !== exp_rdy[c]) begin failures++; $display("FAIL b2b_grant cyc=%0d got=%b exp=%b", c, bus.req_rdy_o, exp_rdy[c]); end
            if (exp_id[c] >= 0) begin
                checks++; if (bus.resp_vld_o !== 1'b1 || bus.resp_id_o !== 2'(exp_id[c])) begin
                    failures++; $display("FAIL b2b_resp cyc=%0d got vld=%b id=%0d exp vld=1 id=%0d", c, bus.resp_vld_o, bus.resp_id_o, exp_id[c]);
                end
            end
            $display("txn b2b cyc=%0d rdy=%b resp_vld=%b id=%0d", c, bus.req_rdy_o, bus.resp_vld_o, bus.resp_id_o);
        end
        @(negedge clk);
        bus.req_vld_i = '0;
        #1;
        checks++; if (bus.resp_vld_o !== 1'b1 || bus.resp_id_o !== 2'd0) begin failures++; $display("FAIL b2b_last got vld=%b id=%0d exp vld=1 id=0", bus.resp_vld_o, bus.resp_id_o); end
        // rr_ptr is now 1: with requesters 0 and 2 pending, 2 wins.
        @(negedge clk);
        set_req(0, 56'h100, 2'd0, 2'd1);
        set_req(2, 56'h300, 2'd1, 2'd1);
        #1;
        checks++; if (bus.req_rdy_o !== 3'b100) begin failures++; $display("FAIL rr_skip got=%b exp=100", bus.req_rdy_o); end
        @(negedge clk);
        bus.req_vld_i = '0;
        @(negedge clk);
        #1;
        checks++; if (bus.resp_id_o !== 2'd2) begin failures++; $display("FAIL rr_skip_id got=%0d exp=2", bus.resp_id_o); end
        $display("txn rr_skip resp_id=%0d", bus.resp_id_o);
        @(negedge clk);
        bus.resp_rdy_i = 1'b0;
    endtask

    task automatic test_priv_lock();
        run_txn(1, 56'h4000, 2'd1, 2'd3, 16'h0008, 16'h0008, 16'h0000, 16'h0008,
                t_rdy, t_chk_vld, t_chk_paddr, t_chk_acc, t_vld, t_id, t_fail, t_hit, t_idx, t_vld_after);
        checks++; if (t_rdy !== 3'b010) begin failures++; $display("FAIL mlock0_grant got=%b exp=010", t_rdy); end
        checks++; if (t_chk_acc !== 2'd1) begin failures++; $display("FAIL mlock0_acc got=%0d exp=1", t_chk_acc); end
        checks++; if (t_id !== 2'd1 || t_idx !== 4'd3 || t_hit !== 1'b1) begin failures++; $display("FAIL mlock0_hit got id=%0d idx=%0d hit=%b exp id=1 idx=3 hit=1", t_id, t_idx, t_hit); end
        checks++; if (t_fail !== 1'b0) begin failures++; $display("FAIL mlock0_fail got=%b exp=0", t_fail); end
        run_txn(1, 56'h4000, 2'd1, 2'd3, 16'h0008, 16'h0008, 16'h0008, 16'h0008,
                t_rdy, t_chk_vld, t_chk_paddr, t_chk_acc, t_vld, t_id, t_fail, t_hit, t_idx, t_vld_after);
        checks++; if (t_fail !== 1'b1) begin failures++; $display("FAIL mlock1_fail got=%b exp=1", t_fail); end
    endtask

    task automatic test_no_match();
        run_txn(2, 56'h9000, 2'd2, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
                t_rdy, t_chk_vld, t_chk_paddr, t_chk_acc, t_vld, t_id, t_fail, t_hit, t_idx, t_vld_after);
        checks++; if (t_fail !== 1'b1) begin failures++; $display("FAIL nomatch_u_fail got=%b exp=1", t_fail); end
        checks++; if (t_hit !== 1'b0 || t_idx !== 4'd0 || t_id !== 2'd2) begin failures++; $display("FAIL nomatch_u_hit got hit=%b idx=%0d id=%0d exp hit=0 idx=0 id=2", t_hit, t_idx, t_id); end
        run_txn(2, 56'h9000, 2'd2, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
                t_rdy, t_chk_vld, t_chk_paddr, t_chk_acc, t_vld, t_id, t_fail, t_hit, t_idx, t_vld_after);
        checks++; if (t_fail !== 1'b0) begin failures++; $display("FAIL nomatch_m_fail got=%b exp=0", t_fail); end
        run_txn(2, 56'h9000, 2'd2, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                t_rdy, t_chk_vld, t_chk_paddr, t_chk_acc, t_vld, t_id, t_fail, t_hit, t_idx, t_vld_after);
        checks++; if (t_fail !== 1'b0) begin failures++; $display("FAIL noactive_u_fail got=%b exp=0", t_fail); end
    endtask

    task automatic test_priority();
        run_txn(0, 56'hA000, 2'd0, 2'd1, 16'h0003, 16'h0002, 16'h0000, 16'h0003,
                t_rdy, t_chk_vld, t_chk_paddr, t_chk_acc, t_vld, t_id, t_fail, t_hit, t_idx, t_vld_after);
        checks++; if (t_idx !== 4'd0 || t_fail !== 1'b0) begin failures++; $display("FAIL prio_low got idx=%0d fail=%b exp idx=0 fail=0", t_idx, t_fail); end
        run_txn(0, 56'hA000, 2'd0, 2'd0, 16'h8000, 16'h8000, 16'h0000, 16'h8000,
                t_rdy, t_chk_vld, t_chk_paddr, t_chk_acc, t_vld, t_id, t_fail, t_hit, t_idx, t_vld_after);
        checks++; if (t_idx !== 4'd15 || t_fail !== 1'b1 || t_hit !== 1'b1) begin failures++; $display("FAIL prio_top got idx=%0d fail=%b hit=%b exp idx=15 fail=1 hit=1", t_idx, t_fail, t_hit); end
    endtask

    task automatic test_resp_stall();
        do_reset();
        @(negedge clk);
        set_req(0, 56'hB000, 2'd0, 2'd1);
        #1;
        checks++; if (bus.req_rdy_o !== 3'b001) begin failures++; $display("FAIL stall_grant got=%b exp=001", bus.req_rdy_o); end
        @(negedge clk);
        bus.req_vld_i = '0;
        set_req(1, 56'hC000, 2'd1, 2'd1);
        set_ent(16'h0010, 16'h0010, 16'h0000, 16'h0010);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.resp_vld_o !== 1'b1 || bus.resp_id_o !== 2'd0 || bus.resp_fail_o !== 1'b1 || bus.resp_hit_idx_o !== 4'd4) begin
                failures++; $display("FAIL stall_hold cyc=%0d got vld=%b id=%0d fail=%b idx=%0d exp 1/0/1/4", c, bus.resp_vld_o, bus.resp_id_o, bus.resp_fail_o, bus.resp_hit_idx_o);
            end
            checks++; if (bus.req_rdy_o !== 3'b000) begin failures++; $display("FAIL stall_nogrant cyc=%0d got=%b exp=000", c, bus.req_rdy_o); end
            $display("txn stall cyc=%0d resp_vld=%b rdy=%b", c, bus.resp_vld_o, bus.req_rdy_o);
        end
        @(negedge clk);
        bus.resp_rdy_i    = 1'b1;
        bus.cfg_wr_pend_i = 1'b1;
        #1;
        checks++; if (bus.req_rdy_o !== 3'b000) begin failures++; $display("FAIL cfgpend_resp got=%b exp=000", bus.req_rdy_o); end
        @(negedge clk);
        bus.resp_rdy_i = 1'b0;
        #1;
        checks++; if (bus.resp_vld_o !== 1'b0) begin failures++; $display("FAIL cfgpend_idle_vld got=%b exp=0", bus.resp_vld_o); end
        checks++; if (bus.req_rdy_o !== 3'b000) begin failures++; $display("FAIL cfgpend_idle1 got=%b exp=000", bus.req_rdy_o); end
        @(negedge clk);
        #1;
        checks++; if (bus.req_rdy_o !== 3'b000) begin failures++; $display("FAIL cfgpend_idle2 got=%b exp=000", bus.req_rdy_o); end
        @(negedge clk);
        bus.cfg_wr_pend_i = 1'b0;
        #1;
        checks++; if (bus.req_rdy_o !== 3'b010) begin failures++; $display("FAIL cfgpend_release got=%b exp=010", bus.req_rdy_o); end
        // A CSR write arriving during CHECK must not abort it.
        @(negedge clk);
        bus.req_vld_i     = '0;
        bus.cfg_wr_pend_i = 1'b1;
        set_ent(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #1;
        checks++; if (bus.chk_vld_o !== 1'b1 || bus.chk_paddr_o !== 56'hC000) begin failures++; $display("FAIL cfgpend_check got vld=%b paddr=%h exp vld=1 paddr=c000", bus.chk_vld_o, bus.chk_paddr_o); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_vld_o !== 1'b1 || bus.resp_id_o !== 2'd1) begin failures++; $display("FAIL cfgpend_resp_done got vld=%b id=%0d exp vld=1 id=1", bus.resp_vld_o, bus.resp_id_o); end
        $display("txn cfgpend resp_vld=%b id=%0d", bus.resp_vld_o, bus.resp_id_o);
        bus.resp_rdy_i    = 1'b1;
        bus.cfg_wr_pend_i = 1'b0;
        @(negedge clk);
        bus.resp_rdy_i = 1'b0;
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.flush_i = 1'b1;
        set_req(1, 56'hD000, 2'd0, 2'd1);
        #1;
        checks++; if (bus.req_rdy_o !== 3'b000) begin failures++; $display("FAIL flush_idle got=%b exp=000", bus.req_rdy_o); end
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        checks++; if (bus.req_rdy_o !== 3'b010) begin failures++; $display("FAIL flush_idle_release got=%b exp=010", bus.req_rdy_o); end
        @(negedge clk);
        bus.req_vld_i = '0;
        bus.flush_i   = 1'b1;
        set_ent(16'h0001, 16'h0001, 16'h0000, 16'h0001);
        #1;
        checks++; if (bus.chk_vld_o !== 1'b1) begin failures++; $display("FAIL flush_check_vld got=%b exp=1", bus.chk_vld_o); end
        @(negedge clk);
        bus.flush_i = 1'b0;
        set_req(2, 56'hE000, 2'd2, 2'd1);
        #1;
        checks++; if (bus.resp_vld_o !== 1'b0 || bus.chk_vld_o !== 1'b0) begin failures++; $display("FAIL flush_check_drop got resp_vld=%b chk_vld=%b exp 0/0", bus.resp_vld_o, bus.chk_vld_o); end
        checks++; if (bus.req_rdy_o !== 3'b100) begin failures++; $display("FAIL flush_check_regrant got=%b exp=100", bus.req_rdy_o); end
        @(negedge clk);
        bus.req_vld_i = '0;
        @(negedge clk);
        set_req(0, 56'h1234, 2'd1, 2'd0);
        #1;
        checks++; if (bus.resp_vld_o !== 1'b1 || bus.resp_id_o !== 2'd2 || bus.resp_hit_idx_o !== 4'd0 || bus.resp_hit_o !== 1'b1) begin
            failures++; $display("FAIL flush_pre_resp got vld=%b id=%0d hit=%b idx=%0d exp 1/2/1/0", bus.resp_vld_o, bus.resp_id_o, bus.resp_hit_o, bus.resp_hit_idx_o);
        end
        bus.flush_i    = 1'b1;
        bus.resp_rdy_i = 1'b1;
        #1;
        checks++; if (bus.req_rdy_o !== 3'b000) begin failures++; $display("FAIL flush_resp_nogrant got=%b exp=000", bus.req_rdy_o); end
        @(negedge clk);
        bus.flush_i    = 1'b0;
        bus.resp_rdy_i = 1'b0;
        set_ent(16'h0080, 16'h0080, 16'h0000, 16'h0080);
        #1;
        checks++; if (bus.resp_vld_o !== 1'b0) begin failures++; $display("FAIL flush_resp_drop got=%b exp=0", bus.resp_vld_o); end
        checks++; if (bus.req_rdy_o !== 3'b001) begin failures++; $display("FAIL flush_resp_regrant got=%b exp=001", bus.req_rdy_o); end
        $display("txn flush resp_vld=%b rdy=%b", bus.resp_vld_o, bus.req_rdy_o);
        @(negedge clk);
        bus.req_vld_i = '0;
        @(negedge clk);
        #1;
        checks++; if (bus.resp_vld_o !== 1'b1 || bus.resp_fail_o !== 1'b1 || bus.resp_hit_idx_o !== 4'd7) begin
            failures++; $display("FAIL prereset_resp got vld=%b fail=%b idx=%0d exp 1/1/7", bus.resp_vld_o, bus.resp_fail_o, bus.resp_hit_idx_o);
        end
        rstn = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.resp_vld_o !== 1'b0 || bus.chk_vld_o !== 1'b0 || bus.req_rdy_o !== 3'b000) begin
            failures++; $display("FAIL midreset_strobes got resp=%b chk=%b rdy=%b exp 0/0/000", bus.resp_vld_o, bus.chk_vld_o, bus.req_rdy_o);
        end
        checks++; if (bus.chk_paddr_o !== 56'h0 || bus.chk_access_type_o !== 2'd0) begin failures++; $display("FAIL midreset_chk got paddr=%h acc=%0d exp 0/0", bus.chk_paddr_o, bus.chk_access_type_o); end
        checks++; if ({bus.resp_fail_o, bus.resp_hit_o, bus.resp_hit_idx_o, bus.resp_id_o} !== 8'h00) begin
            failures++; $display("FAIL midreset_resp got=%b exp=0", {bus.resp_fail_o, bus.resp_hit_o, bus.resp_hit_idx_o, bus.resp_id_o});
        end
        rstn = 1'b1;
        set_ent('0, '0, '0, '0);
        set_req(0, 56'h10, 2'd0, 2'd1);
        set_req(1, 56'h20, 2'd0, 2'd1);
        #1;
        checks++; if (bus.req_rdy_o !== 3'b001) begin failures++; $display("FAIL midreset_rrptr got=%b exp=001", bus.req_rdy_o); end
        $display("txn post_reset rdy=%b", bus.req_rdy_o);
        @(negedge clk);
        bus.req_vld_i = '0;
        @(negedge clk);
        bus.resp_rdy_i = 1'b1;
        @(negedge clk);
        bus.resp_rdy_i = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        test_reset();
        test_single_ptw();
        test_back_to_back();
        test_priv_lock();
        test_no_match();
        test_priority();
        test_resp_stall();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rvh_pmp_check_ctrl.md
Name: rvh_pmp_check_ctrl

Overview:
- Shares one PMP permission-check port across NUM_REQ requesters (0 = PTW, 1 = ITLB, 2 = DTLB by default).
- Arbitrates round-robin, sequences a request through the PMP entry array, resolves the per-entry match/fail vectors with lowest-index priority and privilege/lock rules, and returns a registered verdict with a valid/ready handshake.
- Sits in rvh_mmu between the TLB/PTW miss paths and the rvh_pmp entry array.

Parameters:
- NUM_REQ, 3, number of requesters (≥2).
- NUM_ENTRY, 16, number of PMP entries.
- PADDR_WIDTH, 56, physical address width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_vld_i  in  NUM_REQ  per-requester request valid
- req_paddr_i  in  NUM_REQ*PADDR_WIDTH  packed paddr; requester i at [i*PADDR_WIDTH +: PADDR_WIDTH]
- req_access_type_i  in  NUM_REQ*2  packed access type (0 R, 1 W, 2 X)
- req_priv_lvl_i  in  NUM_REQ*2  packed privilege (0 U, 1 S, 3 M)
- req_rdy_o  out  NUM_REQ  one-hot grant; a request is accepted on the cycle where vld & rdy
- chk_vld_o  out  1  check strobe to entry array
- chk_paddr_o  out  PADDR_WIDTH  latched paddr to entries
- chk_access_type_o  out  2  latched access type to entries
- entry_match_i  in  NUM_ENTRY  per-entry match
- entry_fail_i  in  NUM_ENTRY  per-entry permission fail
- entry_lock_i  in  NUM_ENTRY  per-entry pmpcfg.L
- entry_active_i  in  NUM_ENTRY  per-entry A != OFF
- cfg_wr_pend_i  in  1  pmpcfg/pmpaddr CSR write in flight
- flush_i  in  1  abort the in-flight check
- resp_vld_o  out  1  verdict valid
- resp_id_o  out  $clog2(NUM_REQ)  requester index
- resp_fail_o  out  1  access fault
- resp_hit_o  out  1  some entry matched
- resp_hit_idx_o  out  $clog2(NUM_ENTRY)  winning entry; 0 when no hit
- resp_rdy_i  in  1  consumer accepts the verdict

Behaviour:
- FSM has three states: IDLE, CHECK and RESP. Reset puts it in IDLE with rr_ptr = 0 and all outputs 0.
- IDLE:
  - If cfg_wr_pend_i = 0 and any req_vld_i is set, grant the first valid requester searching from rr_ptr upward, modulo NUM_REQ.
  - The grant is asserted on req_rdy_o combinationally in the same cycle.
  - On the grant, latch paddr, access type, priv and id; set rr_ptr = (grant id + 1) mod NUM_REQ; go to CHECK.
  - If cfg_wr_pend_i = 1, req_rdy_o stays 0.
- CHECK (one cycle):
  - chk_vld_o = 1 and chk_* carry the latched values.
  - Sample the entry vectors, compute the verdict, register it, and go to RESP.
- Verdict rules:
  - j is the lowest index with entry_match_i[j] = 1.
  - Hit, priv = M, entry_lock_i[j] = 0: fail = 0.
  - Hit, otherwise: fail = entry_fail_i[j].
  - No hit, priv = M: fail = 0.
  - No hit, priv ≠ M: fail = |entry_active_i.
  - resp_hit_o = |entry_match_i and resp_hit_idx_o = j.
- RESP:
  - resp_* are held stable until resp_rdy_i = 1.
  - On handshake, if cfg_wr_pend_i = 0 and some req_vld_i is set, grant in the same cycle (same round-robin rule) and go to CHECK. Otherwise go to IDLE.
  - Peak throughput is one check per 2 cycles.
- cfg_wr_pend_i only blocks new grants. A CHECK already in progress completes.
- flush_i has priority over all other events:
  - In CHECK or RESP: go to IDLE; the response is dropped, resp_vld_o = 0 next cycle, and no grant happens that cycle.
  - In IDLE: no grant that cycle.
- Reset mid-operation: return to IDLE, drop any pending response, rr_ptr = 0.
- A requester must hold req_* stable while req_vld_i = 1 and not granted. The block latches on grant, so inputs may change afterwards.
- Round-robin wrap: with rr_ptr = NUM_REQ-1 the search order is NUM_REQ-1, 0, 1, and so on.

Decomposition:
- Shared package rvh_pmp_pkg holds:
  - PMP_ACCESS_TYPE_R/W/X
  - PRIV_LVL_U/S/M
  - PMPCFG_A_OFF/TOR/NA4/NAPOT
  - the FSM state encoding for this block
- Sub-module rvh_pmp_prio_enc: parameterised lowest-index-first priority encoder producing a valid bit and an index. It is used for entry resolution and, with a rotated input, for the round-robin grant.

Test Plan:
1. Single PTW request: paddr 0x8000_0000, R, priv S; entries 2 and 5 match; entry_fail = 0x0020 → resp_hit_idx = 2, resp_fail = 0, resp_id = 0, resp_vld 2 cycles after grant.
2. All three requesters valid continuously, resp_rdy_i = 1 → grants 0, 1, 2, 0, each 2 cycles apart; rr_ptr wraps correctly.
3. Priv M, entry 3 matches with fail = 1:
   - lock = 0 → resp_fail = 0.
   - Same request with lock = 1 → resp_fail = 1.
4. No match, entry_active = 0x0001:
   - priv U → resp_fail = 1.
   - priv M → resp_fail = 0.
   - entry_active = 0 with priv U → resp_fail = 0.
5. resp_rdy_i low 4 cycles → resp_* stable, no new grant. cfg_wr_pend_i high in IDLE → req_rdy_o = 0 until it drops.
6. flush_i asserted in CHECK, and separately in RESP → resp_vld_o = 0 next cycle, state IDLE, next request granted normally. Reset mid-RESP → all outputs 0.
